// File: rtl/axil_cmd_master_if.sv
`default_nettype none
// ============================================================================
// axi4_lite_if - AXI4-Lite bus bundle with master (m) and slave (s) modports.
// Rev 1.0
// ============================================================================
interface axi4_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport m (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport s (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface
`default_nettype wire

// File: rtl/axil_cmd_master.sv
`default_nettype none
// ============================================================================
// axil_cmd_master - single-outstanding AXI4-Lite initiator driven by a
// cmd/rsp handshake. Optional watchdog: AXIL_MST_TIMEOUT_EN. Rev 1.0
// ============================================================================
module axil_cmd_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ADDR_W-1:0]   offset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  axi4_lite_if.m              axi
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WR_B = 3'd2,
    RD_A = 3'd3,
    RD_R = 3'd4,
    RSP  = 3'd5
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] tgt_addr;
  logic              busy;
  logic              step_done;
  logic              timeout_hit;
  logic              abort;

  assign tgt_addr    = cmd_addr + offset;
  assign axi.awprot  = 3'b000;
  assign axi.arprot  = 3'b000;
  assign busy        = state inside {WR, WR_B, RD_A, RD_R};
  assign abort       = timeout_hit && busy && !step_done;

  always_comb begin
    step_done = 1'b0;
    case (state)
      WR:      step_done = (!axi.awvalid || axi.awready) && (!axi.wvalid || axi.wready);
      WR_B:    step_done = axi.bvalid;
      RD_A:    step_done = axi.arready;
      RD_R:    step_done = axi.rvalid;
      default: step_done = 1'b0;
    endcase
  end

`ifdef AXIL_MST_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] wd_cnt;

  assign timeout_hit = (wd_cnt == CNT_LAST);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      wd_cnt <= '0;
    else if (state == IDLE)
      wd_cnt <= '0;
    else if (busy)
      wd_cnt <= wd_cnt + CNT_W'(1);
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= 2'b00;
      axi.awvalid <= 1'b0;
      axi.wvalid  <= 1'b0;
      axi.arvalid <= 1'b0;
      axi.bready  <= 1'b0;
      axi.rready  <= 1'b0;
      axi.awaddr  <= '0;
      axi.araddr  <= '0;
      axi.wdata   <= '0;
      axi.wstrb   <= '0;
`ifdef AXIL_MST_TIMEOUT_EN
      rsp_timeout <= 1'b0;
`endif
    end else if (abort) begin
      // Watchdog expiry: withdraw every handshake and answer with SLVERR.
      axi.awvalid <= 1'b0;
      axi.wvalid  <= 1'b0;
      axi.arvalid <= 1'b0;
      axi.bready  <= 1'b0;
      axi.rready  <= 1'b0;
      rsp_valid   <= 1'b1;
      rsp_resp    <= 2'b10;
      rsp_rdata   <= '0;
`ifdef AXIL_MST_TIMEOUT_EN
      rsp_timeout <= 1'b1;
`endif
      state       <= RSP;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              axi.awaddr  <= tgt_addr;
              axi.wdata   <= cmd_wdata;
              axi.wstrb   <= cmd_wstrb;
              axi.awvalid <= 1'b1;
              axi.wvalid  <= 1'b1;
              state       <= WR;
            end else begin
              axi.araddr  <= tgt_addr;
              axi.arvalid <= 1'b1;
              state       <= RD_A;
            end
          end
        end
        WR: begin
          // AW and W complete independently, in any order.
          if (axi.awready) axi.awvalid <= 1'b0;
          if (axi.wready)  axi.wvalid  <= 1'b0;
          if (step_done) begin
            axi.bready <= 1'b1;
            state      <= WR_B;
          end
        end
        WR_B: begin
          if (axi.bvalid) begin
            axi.bready <= 1'b0;
            rsp_resp   <= axi.bresp;
            rsp_rdata  <= '0;
            rsp_valid  <= 1'b1;
            state      <= RSP;
          end
        end
        RD_A: begin
          if (axi.arready) begin
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
            state       <= RD_R;
          end
        end
        RD_R: begin
          if (axi.rvalid) begin
            axi.rready <= 1'b0;
            rsp_rdata  <= axi.rdata;
            rsp_resp   <= axi.rresp;
            rsp_valid  <= 1'b1;
            state      <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            cmd_ready   <= 1'b1;
`ifdef AXIL_MST_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axil_cmd_master.sv
`default_nettype none
// ============================================================================
// tb_axil_cmd_master - directed bench for axil_cmd_master with a small
// configurable AXI4-Lite memory slave. Rev 1.0
// ============================================================================
module tb_axil_cmd_master;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] offset = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;

  axi4_lite_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axil_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .offset(offset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .axi(bus)
  );

  always #5 aclk = ~aclk;

  // ---------------- slave model ----------------
  int          aw_dly = 0, w_dly = 0, b_dly = 0;
  logic        ar_never = 1'b0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic        r_ovr = 1'b0;
  logic [31:0] r_ovr_data = '0;

  int          aw_cnt, w_cnt, ar_cnt, b_wait;
  logic        aw_got, w_got;
  logic [31:0] sl_awaddr, sl_wdata;
  logic [3:0]  sl_wstrb;
  logic [31:0] mem [0:255];
  logic        aw_hs, w_hs, ar_hs, aw_now, w_now;
  logic [31:0] a_now, d_now;
  logic [3:0]  s_now;

  assign bus.awready = (aw_cnt >= aw_dly);
  assign bus.wready  = (w_cnt >= w_dly);
  assign bus.arready = !ar_never && (ar_cnt >= 0);
  assign aw_hs  = bus.awvalid && bus.awready;
  assign w_hs   = bus.wvalid && bus.wready;
  assign ar_hs  = bus.arvalid && bus.arready;
  assign aw_now = aw_got || aw_hs;
  assign w_now  = w_got || w_hs;
  assign a_now  = aw_got ? sl_awaddr : bus.awaddr;
  assign d_now  = w_got ? sl_wdata : bus.wdata;
  assign s_now  = w_got ? sl_wstrb : bus.wstrb;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      sl_awaddr <= '0; sl_wdata <= '0; sl_wstrb <= '0;
      bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
      bus.rvalid <= 1'b0; bus.rdata <= '0; bus.rresp <= 2'b00;
    end else begin
      if (aw_hs) aw_cnt <= 0; else if (bus.awvalid) aw_cnt <= aw_cnt + 1;
      if (w_hs)  w_cnt  <= 0; else if (bus.wvalid)  w_cnt  <= w_cnt + 1;
      if (ar_hs) ar_cnt <= 0; else if (bus.arvalid) ar_cnt <= ar_cnt + 1;
      if (aw_hs) begin aw_got <= 1'b1; sl_awaddr <= bus.awaddr; end
      if (w_hs)  begin w_got <= 1'b1; sl_wdata <= bus.wdata; sl_wstrb <= bus.wstrb; end
      if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
      if (aw_now && w_now && !bus.bvalid) begin
        if (b_wait == b_dly) begin
          bus.bvalid <= 1'b1;
          bus.bresp  <= b_resp_cfg;
          aw_got <= 1'b0; w_got <= 1'b0; b_wait <= 0;
          for (int i = 0; i < 4; i++)
            if (s_now[i]) mem[a_now[9:2]][8*i +: 8] <= d_now[8*i +: 8];
        end else begin
          b_wait <= b_wait + 1;
        end
      end
      if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
      if (ar_hs) begin
        bus.rvalid <= 1'b1;
        bus.rresp  <= r_resp_cfg;
        bus.rdata  <= r_ovr ? r_ovr_data : mem[bus.araddr[9:2]];
      end
    end
  end

  // ---------------- passive monitor (mid-cycle) ----------------
  int          acc_cnt = 0, rsp_cnt = 0, rspv_cyc = 0, stab_err = 0;
  logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
  logic        p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_arv = 1'b0, p_arr = 1'b0;
  logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
  logic [3:0]  p_wstrb = '0;

  always @(negedge aclk) begin
    if (cmd_valid && cmd_ready) acc_cnt++;
    if (rsp_valid && rsp_ready) rsp_cnt++;
    if (rsp_valid) rspv_cyc++;
    if (aw_hs) last_awaddr = bus.awaddr;
    if (w_hs)  last_wdata  = bus.wdata;
    if (ar_hs) last_araddr = bus.araddr;
    if (aresetn) begin
      if (p_awv && !p_awr && (!bus.awvalid || bus.awaddr != p_awaddr)) stab_err++;
      if (p_wv && !p_wr && (!bus.wvalid || bus.wdata != p_wdata || bus.wstrb != p_wstrb)) stab_err++;
      if (p_arv && !p_arr && (!bus.arvalid || bus.araddr != p_araddr)) stab_err++;
    end
    p_awv = bus.awvalid; p_awr = bus.awready; p_awaddr = bus.awaddr;
    p_wv  = bus.wvalid;  p_wr  = bus.wready;  p_wdata = bus.wdata; p_wstrb = bus.wstrb;
    p_arv = bus.arvalid; p_arr = bus.arready; p_araddr = bus.araddr;
  end

  // ---------------- checking helpers ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    while (!cmd_ready && n < 200) begin tick(); n++; end
    check("cmd_ready_before_send", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 200) begin tick(); lat++; end
    check("rsp_valid_arrives", rsp_valid, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, r0, a0, rv0, hold_err, arv;
    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_resp", rsp_resp, 2'b00);
    check("rst_rsp_timeout", rsp_timeout, 1'b0);
    check("rst_axi_valid_ready", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 5'b0);
    aresetn = 1'b1;
    tick();

    // Zero-wait write with base offset
    offset = 32'h100;
    send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    wait_rsp(lat);
    check("wr_latency", lat, 3);
    check("wr_resp", rsp_resp, 2'b00);
    check("wr_rdata_zero", rsp_rdata, 32'h0);
    check("wr_awaddr", last_awaddr, 32'h110);
    check("wr_wdata", last_wdata, 32'hDEADBEEF);
    check("wr_awprot", bus.awprot, 3'b000);
    tick();
    check("wr_cmd_ready_after", cmd_ready, 1'b1);

    // Read back
    send(1'b0, 32'h10, 32'h0, 4'h0);
    wait_rsp(lat);
    check("rd_latency", lat, 3);
    check("rd_rdata", rsp_rdata, 32'hDEADBEEF);
    check("rd_resp", rsp_resp, 2'b00);
    check("rd_timeout", rsp_timeout, 1'b0);
    check("rd_araddr", last_araddr, 32'h110);
    tick();

    // wready 4 cycles ahead of awready, B 5 cycles late, SLVERR passthrough, offset moved mid-flight
    aw_dly = 4; b_dly = 5; b_resp_cfg = 2'b10;
    r0 = rsp_cnt;
    send(1'b1, 32'h20, 32'hA5A55A5A, 4'hF);
    offset = 32'h900;
    wait_rsp(lat);
    check("slow_wr_latency", lat, 12);
    check("slow_wr_bresp", rsp_resp, 2'b10);
    check("slow_wr_awaddr", last_awaddr, 32'h120);
    tick();
    check("slow_wr_single_rsp", rsp_cnt - r0, 1);
    check("aw_w_ar_stability", stab_err, 0);
    offset = 32'h100; aw_dly = 0; b_dly = 0; b_resp_cfg = 2'b00;

    // Response back-pressure with a queued command
    rsp_ready = 1'b0;
    send(1'b0, 32'h10, 32'h0, 4'h0);
    wait_rsp(lat);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'h11112222; cmd_wstrb = 4'h3;
    a0 = acc_cnt;
    hold_err = 0;
    repeat (10) begin
      tick();
      if (!rsp_valid || rsp_rdata !== 32'hDEADBEEF || cmd_ready) hold_err++;
    end
    check("stall_hold", hold_err, 0);
    check("stall_no_accept", acc_cnt - a0, 0);
    rsp_ready = 1'b1;
    tick();
    check("stall_cmd_ready_after_rsp", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    check("stall_accept_after_rsp", acc_cnt - a0, 1);
    wait_rsp(lat);
    check("strb_wr_latency", lat, 3);
    tick();
    send(1'b0, 32'h10, 32'h0, 4'h0);
    wait_rsp(lat);
    check("strb_rd_rdata", rsp_rdata, 32'hDEAD2222);
    tick();

    // DECERR read passthrough
    r_ovr = 1'b1; r_ovr_data = 32'h12345678; r_resp_cfg = 2'b11;
    send(1'b0, 32'h40, 32'h0, 4'h0);
    wait_rsp(lat);
    check("decerr_rdata", rsp_rdata, 32'h12345678);
    check("decerr_resp", rsp_resp, 2'b11);
    tick();
    r_ovr = 1'b0; r_resp_cfg = 2'b00;

    send(1'b0, 32'h20, 32'h0, 4'h0);
    wait_rsp(lat);
    check("slow_wr_readback", rsp_rdata, 32'hA5A55A5A);
    tick();

`ifdef AXIL_MST_TIMEOUT_EN
    ar_never = 1'b1;
    send(1'b0, 32'h30, 32'h0, 4'h0);
    arv = 0; lat = 1;
    while (!rsp_valid && lat < 100) begin
      if (bus.arvalid) arv++;
      tick(); lat++;
    end
    check("to_arvalid_cycles", arv, 16);
    check("to_latency", lat, 17);
    check("to_flag", rsp_timeout, 1'b1);
    check("to_resp", rsp_resp, 2'b10);
    check("to_rdata", rsp_rdata, 32'h0);
    check("to_arvalid_dropped", bus.arvalid, 1'b0);
    tick();
    check("to_flag_cleared", rsp_timeout, 1'b0);
    ar_never = 1'b0;
`endif

    // Reset in the middle of a stalled write
    aw_dly = 8; w_dly = 8;
    send(1'b1, 32'h50, 32'hCAFEF00D, 4'hF);
    tick(); tick();
    check("midrst_valids_before", {bus.awvalid, bus.wvalid}, 2'b11);
    #2 aresetn = 1'b0;
    #1;
    check("midrst_valids_async_drop", {bus.awvalid, bus.wvalid}, 2'b00);
    rv0 = rspv_cyc;
    @(posedge aclk); #1;
    aresetn = 1'b1; aw_dly = 0; w_dly = 0;
    repeat (5) tick();
    check("midrst_no_rsp", rspv_cyc - rv0, 0);
    check("midrst_cmd_ready", cmd_ready, 1'b1);

    send(1'b0, 32'h20, 32'h0, 4'h0);
    wait_rsp(lat);
    check("post_rst_read", rsp_rdata, 32'hA5A55A5A);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
